// File: rtl/mri_sequencer.sv
// mri_sequencer: execute-phase control for memory-reference instructions
// (AND, ADD, LDA, STA, BUN, BSA, ISZ). Resolves indirect addressing, then
// drives the bus select and register/memory strobes for each timing step.
// The main controller hands over with start and gets control back on done.
module mri_sequencer #(
  parameter int WIDTH = 16,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ir,
  input  logic             dr_zero,
  output logic             busy,
  output logic             done,
  output logic [2:0]       bus_sel,
  output logic             ar_ld,
  output logic             ar_inr,
  output logic             pc_ld,
  output logic             pc_inr,
  output logic             dr_ld,
  output logic             dr_inr,
  output logic             ac_ld,
  output logic             e_ld,
  output logic [2:0]       alu_op,
  output logic             mem_wr
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    IND  = 3'd1,
    T4   = 3'd2,
    T5   = 3'd3,
    T6   = 3'd4
  } state_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  localparam logic [2:0] BUS_NONE = 3'b000;
  localparam logic [2:0] BUS_PC   = 3'b001;
  localparam logic [2:0] BUS_DR   = 3'b010;
  localparam logic [2:0] BUS_AC   = 3'b011;
  localparam logic [2:0] BUS_AR   = 3'b101;
  localparam logic [2:0] BUS_MEM  = 3'b110;

  state_t     state_r;
  state_t     next_s;
  logic [2:0] op_r;
  logic [2:0] ir_op_s;
  logic       ir_ind_s;
  logic       accept_s;
  logic       unused_s;

  assign ir_op_s  = ir[WIDTH-2 -: 3];
  assign ir_ind_s = ir[WIDTH-1];
  assign accept_s = (state_r == IDLE) && start && (ir_op_s != OP_REG);
  // The address field is consumed by the datapath (AR), not by this block.
  assign unused_s = ^ir[AW-1:0];

  // State register and opcode capture; reset wins over a concurrent start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      op_r    <= 3'd0;
    end else begin
      state_r <= next_s;
      if (accept_s) begin
        op_r <= ir_op_s;
      end
    end
  end

  // Next-state and strobe decode from state, captured opcode and dr_zero.
  always_comb begin
    next_s  = IDLE;
    busy    = (state_r != IDLE);
    done    = 1'b0;
    bus_sel = BUS_NONE;
    ar_ld   = 1'b0;
    ar_inr  = 1'b0;
    pc_ld   = 1'b0;
    pc_inr  = 1'b0;
    dr_ld   = 1'b0;
    dr_inr  = 1'b0;
    ac_ld   = 1'b0;
    e_ld    = 1'b0;
    alu_op  = 3'b000;
    mem_wr  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_s = ir_ind_s ? IND : T4;
        end else begin
          next_s = IDLE;
        end
      end
      IND: begin
        bus_sel = BUS_MEM;
        ar_ld   = 1'b1;
        next_s  = T4;
      end
      T4: begin
        case (op_r)
          OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
            bus_sel = BUS_MEM;
            dr_ld   = 1'b1;
            next_s  = T5;
          end
          OP_STA: begin
            bus_sel = BUS_AC;
            mem_wr  = 1'b1;
            done    = 1'b1;
          end
          OP_BUN: begin
            bus_sel = BUS_AR;
            pc_ld   = 1'b1;
            done    = 1'b1;
          end
          OP_BSA: begin
            bus_sel = BUS_PC;
            mem_wr  = 1'b1;
            ar_inr  = 1'b1;
            next_s  = T5;
          end
          default: next_s = IDLE;
        endcase
      end
      T5: begin
        case (op_r)
          OP_AND: begin
            ac_ld  = 1'b1;
            alu_op = 3'b001;
            done   = 1'b1;
          end
          OP_ADD: begin
            ac_ld  = 1'b1;
            e_ld   = 1'b1;
            alu_op = 3'b010;
            done   = 1'b1;
          end
          OP_LDA: begin
            ac_ld  = 1'b1;
            alu_op = 3'b011;
            done   = 1'b1;
          end
          OP_BSA: begin
            bus_sel = BUS_AR;
            pc_ld   = 1'b1;
            done    = 1'b1;
          end
          OP_ISZ: begin
            dr_inr = 1'b1;
            next_s = T6;
          end
          default: next_s = IDLE;
        endcase
      end
      T6: begin
        if (op_r == OP_ISZ) begin
          bus_sel = BUS_DR;
          mem_wr  = 1'b1;
          pc_inr  = dr_zero;
          done    = 1'b1;
        end else begin
          next_s = IDLE;
        end
      end
      default: next_s = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mri_sequencer.sv
// tb_mri_sequencer: directed scoreboard bench for mri_sequencer. Expected
// per-cycle output vectors are queued when an instruction is started and
// popped one per clock as the DUT steps through the instruction.
module tb_mri_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] ir;
  logic        dr_zero;
  logic        busy, done, ar_ld, ar_inr, pc_ld, pc_inr;
  logic        dr_ld, dr_inr, ac_ld, e_ld, mem_wr;
  logic [2:0]  bus_sel, alu_op;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int done_ref = 0;

  logic [16:0] exp_q[$];
  logic [16:0] obs;

  // strobe field order: ar_ld ar_inr pc_ld pc_inr dr_ld dr_inr ac_ld e_ld
  localparam logic [7:0]  S_AR_LD  = 8'b1000_0000;
  localparam logic [7:0]  S_AR_INR = 8'b0100_0000;
  localparam logic [7:0]  S_PC_LD  = 8'b0010_0000;
  localparam logic [7:0]  S_PC_INR = 8'b0001_0000;
  localparam logic [7:0]  S_DR_LD  = 8'b0000_1000;
  localparam logic [7:0]  S_DR_INR = 8'b0000_0100;
  localparam logic [7:0]  S_AC_LD  = 8'b0000_0010;
  localparam logic [7:0]  S_E_LD   = 8'b0000_0001;
  localparam logic [16:0] IDLE_V   = 17'd0;

  mri_sequencer #(.WIDTH(16), .AW(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ir(ir), .dr_zero(dr_zero),
    .busy(busy), .done(done), .bus_sel(bus_sel),
    .ar_ld(ar_ld), .ar_inr(ar_inr), .pc_ld(pc_ld), .pc_inr(pc_inr),
    .dr_ld(dr_ld), .dr_inr(dr_inr), .ac_ld(ac_ld), .e_ld(e_ld),
    .alu_op(alu_op), .mem_wr(mem_wr)
  );

  assign obs = {busy, done, bus_sel, ar_ld, ar_inr, pc_ld, pc_inr,
                dr_ld, dr_inr, ac_ld, e_ld, alu_op, mem_wr};

  always #5 clk = ~clk;

  // Count done pulses away from the active edge.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Busy-cycle output vector.
  function automatic logic [16:0] bv(input logic d, input logic [2:0] bus,
                                     input logic [7:0] stb, input logic [2:0] alu,
                                     input logic wr);
    return {1'b1, d, bus, stb, alu, wr};
  endfunction

  // Reference behaviour: per-cycle outputs of one instruction, then IDLE.
  task automatic push_expected(input logic [15:0] instr, input logic zero);
    logic [2:0] op;
    op = instr[14:12];
    if (op != 3'd7) begin
      if (instr[15]) exp_q.push_back(bv(1'b0, 3'b110, S_AR_LD, 3'b000, 1'b0));
      case (op)
        3'd0: begin
          exp_q.push_back(bv(1'b0, 3'b110, S_DR_LD, 3'b000, 1'b0));
          exp_q.push_back(bv(1'b1, 3'b000, S_AC_LD, 3'b001, 1'b0));
        end
        3'd1: begin
          exp_q.push_back(bv(1'b0, 3'b110, S_DR_LD, 3'b000, 1'b0));
          exp_q.push_back(bv(1'b1, 3'b000, S_AC_LD | S_E_LD, 3'b010, 1'b0));
        end
        3'd2: begin
          exp_q.push_back(bv(1'b0, 3'b110, S_DR_LD, 3'b000, 1'b0));
          exp_q.push_back(bv(1'b1, 3'b000, S_AC_LD, 3'b011, 1'b0));
        end
        3'd3: exp_q.push_back(bv(1'b1, 3'b011, 8'd0, 3'b000, 1'b1));
        3'd4: exp_q.push_back(bv(1'b1, 3'b101, S_PC_LD, 3'b000, 1'b0));
        3'd5: begin
          exp_q.push_back(bv(1'b0, 3'b001, S_AR_INR, 3'b000, 1'b1));
          exp_q.push_back(bv(1'b1, 3'b101, S_PC_LD, 3'b000, 1'b0));
        end
        default: begin
          exp_q.push_back(bv(1'b0, 3'b110, S_DR_LD, 3'b000, 1'b0));
          exp_q.push_back(bv(1'b0, 3'b000, S_DR_INR, 3'b000, 1'b0));
          exp_q.push_back(bv(1'b1, 3'b010, zero ? S_PC_INR : 8'd0, 3'b000, 1'b1));
        end
      endcase
    end
    exp_q.push_back(IDLE_V);
  endtask

  // Pop one expected vector and compare it with the current DUT outputs.
  task automatic check(input string tag);
    logic [16:0] e;
    if (exp_q.size() == 0) begin
      e = IDLE_V;
    end else begin
      e = exp_q.pop_front();
    end
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, e);
    end
  endtask

  // Compare the done-pulse count against the bench's own tally.
  task automatic check_done(input string tag);
    checks++;
    assert (done_cnt === done_ref) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, done_cnt, done_ref);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an instruction from IDLE and check every cycle through to IDLE.
  task automatic run_instr(input logic [15:0] instr, input logic zero, input string tag);
    push_expected(instr, zero);
    if (instr[14:12] != 3'd7) done_ref++;
    start   = 1'b1;
    ir      = instr;
    dr_zero = zero;
    tick();
    start = 1'b0;
    ir    = 16'hFFFF;
    while (exp_q.size() > 0) begin
      check(tag);
      tick();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b1;
    ir      = 16'h1005;
    dr_zero = 1'b0;

    // Reset held with start asserted: stays idle.
    tick();
    exp_q.push_back(IDLE_V);
    check("reset_hold_1");
    tick();
    exp_q.push_back(IDLE_V);
    check("reset_hold_2");
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    exp_q.push_back(IDLE_V);
    check("reset_release");

    run_instr(16'h1005, 1'b0, "add");
    run_instr(16'h0004, 1'b0, "and");
    run_instr(16'hA123, 1'b0, "lda_ind");
    run_instr(16'h3002, 1'b0, "sta");
    run_instr(16'hC100, 1'b1, "bun_ind");
    run_instr(16'h5040, 1'b0, "bsa");
    run_instr(16'h6010, 1'b0, "isz_nz");
    run_instr(16'h6010, 1'b1, "isz_z");
    run_instr(16'h7800, 1'b0, "op7_ignored");
    check_done("done_count_a");

    // Start pulsed while ISZ is busy: ignored.
    push_expected(16'h6010, 1'b0);
    done_ref++;
    start = 1'b1;
    ir    = 16'h6010;
    tick();
    start = 1'b0;
    check("isz_busy_c1");
    start = 1'b1;
    ir    = 16'h3002;
    tick();
    start = 1'b0;
    check("isz_busy_c2");
    tick();
    check("isz_busy_c3");
    tick();
    check("isz_busy_idle");
    check_done("done_count_b");

    // Start held through a BUN done cycle: accepted only in the next IDLE.
    done_ref += 2;
    start = 1'b1;
    ir    = 16'h4010;
    tick();
    exp_q.push_back(bv(1'b1, 3'b101, S_PC_LD, 3'b000, 1'b0));
    check("b2b_done1");
    tick();
    exp_q.push_back(IDLE_V);
    check("b2b_gap");
    tick();
    start = 1'b0;
    exp_q.push_back(bv(1'b1, 3'b101, S_PC_LD, 3'b000, 1'b0));
    check("b2b_done2");
    tick();
    exp_q.push_back(IDLE_V);
    check("b2b_idle");
    check_done("done_count_c");

    // Reset in ISZ T5: abandoned, no further strobes.
    push_expected(16'h6010, 1'b1);
    start   = 1'b1;
    ir      = 16'h6010;
    dr_zero = 1'b1;
    tick();
    start = 1'b0;
    check("isz_rst_t4");
    tick();
    check("isz_rst_t5");
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    exp_q.push_back(IDLE_V);
    check("isz_rst_out");
    rst_n = 1'b1;
    tick();
    exp_q.push_back(IDLE_V);
    check("isz_rst_after");
    tick();
    exp_q.push_back(IDLE_V);
    check("isz_rst_quiet");
    check_done("done_count_d");

    run_instr(16'h3002, 1'b0, "sta_after_rst");
    check_done("done_count_e");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mri_sequencer.md
# mri_sequencer

Execute-phase sequencer for memory-reference instructions (opcodes 000–110) of the 16-bit accumulator CPU. It takes over from the fetch/decode controller once IR is loaded and AR holds IR[11:0]. It resolves indirect addressing, then drives the common-bus select and the register and memory strobes for AND, ADD, LDA, STA, BUN, BSA and ISZ. It returns control through a start/done handshake. Register-reference and I/O instructions stay in the main controller.

## Interface
- WIDTH, 16, instruction/data word width
- AW, 12, address width (IR[AW-1:0])

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset: one clock; reset is synchronous and active-low
- start  in  1  request from fetch controller; sampled only in IDLE
- ir  in  WIDTH  instruction word; captured on accepted start
- dr_zero  in  1  datapath flag, DR == 0 (combinational)
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse in final execute cycle
- bus_sel  out  3  000 none, 001 PC, 010 DR, 011 AC, 100 IR, 101 AR, 110 MEM, 111 TR
- ar_ld, ar_inr, pc_ld, pc_inr, dr_ld, dr_inr  out  1 each  register load/increment strobes
- ac_ld  out  1  load AC from ALU
- e_ld  out  1  load E from ALU carry
- alu_op  out  3  000 pass, 001 AND, 010 ADD, 011 DR transfer
- mem_wr  out  1  write bus value to M[AR]

## Operation
- States: IDLE, IND, T4, T5, T6. State and captured IR are registered. All outputs decode combinationally from state, captured opcode and dr_zero (Moore, plus dr_zero in T6).
- IDLE + start + ir[14:12] != 111: capture ir. Next state is IND if ir[15] = 1, else T4.
- IDLE + start + opcode 111: ignored. Stay IDLE, no done, no strobes.
- IND: bus_sel=110, ar_ld=1 (AR <- M[AR]). Next state T4.
- AND/ADD/LDA:
  - T4: bus_sel=110, dr_ld.
  - T5: ac_ld with alu_op 001/010/011. ADD also asserts e_ld. Assert done.
- STA: T4: bus_sel=011, mem_wr, done.
- BUN: T4: bus_sel=101, pc_ld, done.
- BSA:
  - T4: bus_sel=001, mem_wr, ar_inr.
  - T5: bus_sel=101, pc_ld, done.
- ISZ:
  - T4: bus_sel=110, dr_ld.
  - T5: dr_inr.
  - T6: bus_sel=010, mem_wr, pc_inr = dr_zero, done.
- The state after any done cycle is IDLE.
- Every strobe not listed for a state is 0. alu_op is 000 outside AND/ADD/LDA T5.

## Timing
- Reset: state IDLE; busy=0, done=0, bus_sel=000, all strobes 0, alu_op=000, captured IR=0. rst_n overrides start in the same cycle.
- Reset mid-operation: outputs return to reset values in the cycle after the rst_n edge. A partially executed instruction is abandoned; no further strobes are issued.
- Latency is measured from the start-accept edge to the done cycle, with cycle 1 being the first cycle after accept:
  - STA, BUN: done in cycle 1.
  - AND, ADD, LDA, BSA: cycle 2.
  - ISZ: cycle 3.
  - Indirect adds +1.
- busy is high in every non-IDLE cycle, including the done cycle, and low in IDLE.
- start while busy is ignored. ir changes while busy have no effect.
- A back-to-back start may be asserted in the done cycle but is sampled in the following IDLE cycle. The minimum gap between done pulses is latency + 1 cycles.
- dr_zero is sampled only in ISZ T6 and is ignored elsewhere.

## Test plan
- Reset: hold rst_n=0 with start=1, ir=16'h1005 → busy=0, bus_sel=000, all strobes 0. Release, then start ir=16'h1005 → T4 bus_sel=110, dr_ld; next cycle ac_ld, alu_op=010, e_ld, done.
- Indirect LDA: start ir=16'h A123 → cycle 1 bus_sel=110, ar_ld; cycle 2 dr_ld; cycle 3 alu_op=011, ac_ld, done; busy high for exactly 3 cycles.
- BSA ir=16'h5040 → cycle 1 bus_sel=001, mem_wr, ar_inr; cycle 2 bus_sel=101, pc_ld, done.
- ISZ ir=16'h6010 twice: first with dr_zero=0 in T6 → mem_wr, bus_sel=010, pc_inr=0; then with dr_zero=1 → pc_inr=1, done in cycle 3 each time.
- Opcode 111: start ir=16'h7800 → stays IDLE, busy=0, no done. Start pulsed during a busy ISZ → ignored, done count unchanged.
- Reset mid-ISZ: assert rst_n=0 in T5 → next cycle all outputs 0, IDLE. A subsequent STA ir=16'h3002 completes with bus_sel=011, mem_wr, done in cycle 1.
